taillight_seq: RTL
==================

TAILLIGHT_SEQ -- requirements
Module: taillight_seq

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, default 2, number of synchronizer flops on each driver input (legal 2..4).
REQ-002 SHALL have port: clk  input  1  system clock; all state on posedge clk.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: tick  input  1  single-cycle step enable from the upstream clock divider; one pulse per step period.
REQ-005 SHALL have port: left  input  1  asynchronous left-turn switch, active-high.
REQ-006 SHALL have port: right  input  1  asynchronous right-turn switch, active-high.
REQ-007 SHALL have port: hazard  input  1  asynchronous hazard switch, active-high.
REQ-008 SHALL have port: lights_l  output  3  left lamps {LC,LB,LA}, active-high.
REQ-009 SHALL have port: lights_r  output  3  right lamps {RC,RB,RA}, active-high.

Function
REQ-010 SHALL pass left, right, hazard (and brake when enabled) through SYNC_STAGES flops before use; synchronized values are called l_s, r_s, h_s, b_s.
REQ-011 SHALL implement a Moore FSM with states IDLE, L1, L2, L3, R1, R2, R3, LR3.
REQ-012 SHALL change state only on a posedge where tick=1; with tick=0 the state holds.
REQ-013 IDLE on tick: h_s=1 or (l_s=1 and r_s=1) -> LR3; else l_s=1 -> L1; else r_s=1 -> R1; else IDLE.
REQ-014 L1->L2->L3->IDLE and R1->R2->R3->IDLE on successive ticks regardless of l_s/r_s (a started sequence completes).
REQ-015 In L1, L2, R1, R2: h_s=1 at a tick SHALL go to LR3 instead (hazard priority); L3/R3 go to IDLE.
REQ-016 LR3 on tick SHALL go to IDLE (hazard blinks on/off at tick rate).
REQ-017 Light decode: IDLE 000/000; L1 001/000; L2 011/000; L3 111/000; R1 000/001; R2 000/011; R3 000/111; LR3 111/111 (lights_l/lights_r).
REQ-018 Outputs SHALL be registered and valid the cycle after the state update (decode from next-state into output flops, zero extra step latency); glitch-free.
REQ-019 Input-to-action latency: switch change visible to FSM after SYNC_STAGES cycles, acted on at the next tick thereafter.
REQ-020 tick asserted for consecutive cycles SHALL step once per cycle (no edge detection inside this block).

Reset
REQ-021 rst=1 SHALL asynchronously force state IDLE, all synchronizer flops 0, lights_l=000, lights_r=000.
REQ-022 rst=1 coincident with tick SHALL win; first step after release needs a tick with rst=0.
REQ-023 Reset mid-sequence (e.g. in L2) SHALL return to IDLE; no sequence resumption.

Configuration
REQ-024 Macro TAILLIGHT_BRAKE_EN SHALL, when defined, add port brake  input  1  asynchronous brake switch, synchronized per REQ-010.
REQ-025 With TAILLIGHT_BRAKE_EN, b_s=1 SHALL overlay outputs only (no new states): IDLE -> 111/111; L1-L3 -> right side 111; R1-R3 -> left side 111; LR3 unchanged.
REQ-026 Without TAILLIGHT_BRAKE_EN, port brake SHALL not exist and behaviour is exactly REQ-011..REQ-020.

Structure
REQ-027 Package taillight_pkg SHALL hold typedef enum state_t (8 states, 3-bit), constants LAMPS_OFF=3'b000, LAMPS_ON=3'b111.
REQ-028 Synchronizer SHALL be sub-module sync_ff (parameter STAGES, async reset to 0), one instance per switch input.

Verification (tick every 4 clk cycles, SYNC_STAGES=2)
REQ-029 rst pulse, no switches, 10 ticks -> lights_l=000, lights_r=000 throughout.
REQ-030 left=1 held, 4 ticks -> lights_l 001, 011, 111, 000 on consecutive steps; lights_r=000.
REQ-031 right=1 for 1 tick then released -> lights_r 001, 011, 111, 000 (sequence completes).
REQ-032 left=1, after L2 set hazard=1 -> next step 111/111, then 000/000; with left=right=1 from IDLE -> 111/111.
REQ-033 rst asserted mid-cycle during L2 -> lights 000/000 immediately, before next posedge; tick with rst=1 -> no step.
REQ-034 With TAILLIGHT_BRAKE_EN: brake=1, left=1 -> lights_r=111 while lights_l steps 001, 011, 111; brake=1 alone -> 111/111.

Source files
------------

// File: rtl/taillight_pkg.sv
// Shared types, lamp constants and pure helper functions for the taillight
// sequencer: the FSM state encoding, the next-state rule and the lamp decode.
package taillight_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        LR3  = 3'd7
    } state_t;

    localparam logic [2:0] LAMPS_OFF = 3'b000;
    localparam logic [2:0] LAMPS_ON  = 3'b111;

    // Next state for one step; hazard pre-empts an unfinished turn sequence,
    // while l/r are ignored once a sequence has started.
    function automatic state_t step_state(input state_t s, input logic l,
                                          input logic r, input logic h);
        state_t n;
        case (s)
            IDLE: begin
                if (h || (l && r)) begin
                    n = LR3;
                end else if (l) begin
                    n = L1;
                end else if (r) begin
                    n = R1;
                end else begin
                    n = IDLE;
                end
            end
            L1:      n = h ? LR3 : L2;
            L2:      n = h ? LR3 : L3;
            L3:      n = IDLE;
            R1:      n = h ? LR3 : R2;
            R2:      n = h ? LR3 : R3;
            R3:      n = IDLE;
            LR3:     n = IDLE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    // Lamp pattern {lights_l, lights_r} for a state; brake lights the side
    // that is not sequencing (both sides when idle).
    function automatic logic [5:0] decode_lamps(input state_t s, input logic brake);
        logic [2:0] ll;
        logic [2:0] rr;
        case (s)
            IDLE:    begin ll = LAMPS_OFF; rr = LAMPS_OFF; end
            L1:      begin ll = 3'b001;    rr = LAMPS_OFF; end
            L2:      begin ll = 3'b011;    rr = LAMPS_OFF; end
            L3:      begin ll = 3'b111;    rr = LAMPS_OFF; end
            R1:      begin ll = LAMPS_OFF; rr = 3'b001;    end
            R2:      begin ll = LAMPS_OFF; rr = 3'b011;    end
            R3:      begin ll = LAMPS_OFF; rr = 3'b111;    end
            LR3:     begin ll = LAMPS_ON;  rr = LAMPS_ON;  end
            default: begin ll = LAMPS_OFF; rr = LAMPS_OFF; end
        endcase
        if (brake) begin
            case (s)
                IDLE:       begin ll = LAMPS_ON; rr = LAMPS_ON; end
                L1, L2, L3: rr = LAMPS_ON;
                R1, R2, R3: ll = LAMPS_ON;
                default:    ll = ll;
            endcase
        end else begin
            ll = ll;
        end
        return {ll, rr};
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous switch input.
// Ports: clk, rst (async active-high, clears chain), d (async in), q (synced out).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{1'b0}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/taillight_seq.sv
// Thunderbird-style taillight sequencer: synchronizes the driver switches and
// steps a Moore FSM once per tick, driving registered lamp outputs.
// Ports: clk, rst (async active-high), tick (step enable), left/right/hazard
// (async switches), lights_l {LC,LB,LA}, lights_r {RC,RB,RA}.
// Build option: define TAILLIGHT_BRAKE_EN to add the brake input, which
// overlays the lamp outputs without adding states.
module taillight_seq
    import taillight_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
`ifdef TAILLIGHT_BRAKE_EN
    input  logic       brake,
`endif
    output logic [2:0] lights_l,
    output logic [2:0] lights_r
);

    logic l_s;
    logic r_s;
    logic h_s;
    logic b_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_l (.clk(clk), .rst(rst), .d(left),   .q(l_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_r (.clk(clk), .rst(rst), .d(right),  .q(r_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_h (.clk(clk), .rst(rst), .d(hazard), .q(h_s));
`ifdef TAILLIGHT_BRAKE_EN
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst(rst), .d(brake),  .q(b_s));
`else
    assign b_s = 1'b0;
`endif

    state_t     state;
    state_t     state_nxt;
    logic [5:0] lamps_nxt;

    // Next state and its lamp pattern; lamps are decoded from the next state so
    // the output flops update on the same edge as the state.
    always_comb begin
        state_nxt = state;
        if (tick) begin
            state_nxt = step_state(state, l_s, r_s, h_s);
        end else begin
            state_nxt = state;
        end
        lamps_nxt = decode_lamps(state_nxt, b_s);
    end

    // State register and registered lamp outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lights_l <= LAMPS_OFF;
            lights_r <= LAMPS_OFF;
        end else begin
            state    <= state_nxt;
            lights_l <= lamps_nxt[5:3];
            lights_r <= lamps_nxt[2:0];
        end
    end

endmodule
